// File: rtl/hot_page_topk_if.sv
// Bus bundle for hot_page_topk: the sketch estimate stream in, and the drain
// port plus status out. The DUT side uses the slave modport.
interface hot_page_topk_if #(
    parameter int ADDR_SIZE = 22,
    parameter int CNT_SIZE  = 32
);
    logic                 in_valid;
    logic [ADDR_SIZE-1:0] in_addr;
    logic [CNT_SIZE-1:0]  in_cnt;
    logic                 drain_start;
    logic                 out_valid;
    logic                 out_ready;
    logic [ADDR_SIZE-1:0] out_addr;
    logic [CNT_SIZE-1:0]  out_cnt;
    logic                 out_last;
    logic                 busy;
    logic [15:0]          drop_cnt;

    modport master (
        output in_valid, in_addr, in_cnt, drain_start, out_ready,
        input  out_valid, out_addr, out_cnt, out_last, busy, drop_cnt
    );

    modport slave (
        input  in_valid, in_addr, in_cnt, drain_start, out_ready,
        output out_valid, out_addr, out_cnt, out_last, busy, drop_cnt
    );
endinterface

// File: rtl/hot_page_topk.sv
// Sorted top-K table of the hottest page addresses fed by the count-min sketch.
// Single-cycle sorted insert/raise; drained in descending count order on request.
module hot_page_topk #(
    parameter int K              = 8,
    parameter int ADDR_SIZE      = 22,
    parameter int CNT_SIZE       = 32,
    parameter bit CLEAR_ON_DRAIN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    hot_page_topk_if.slave    tk_if
);
    localparam int SLOT_W = $clog2(K);
    localparam int CNT_W  = $clog2(K + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [K-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < K; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    logic [ADDR_SIZE-1:0] addr_q [K];
    logic [ADDR_SIZE-1:0] addr_d [K];
    logic [CNT_SIZE-1:0]  cnt_q  [K];
    logic [CNT_SIZE-1:0]  cnt_d  [K];
    logic [K-1:0]         valid_q, valid_d;

    state_t               state_q, state_d;
    logic [SLOT_W-1:0]    beat_q, beat_d, beat_nxt_s;
    logic                 out_valid_q, out_valid_d;
    logic [ADDR_SIZE-1:0] out_addr_q, out_addr_d;
    logic [CNT_SIZE-1:0]  out_cnt_q, out_cnt_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q, busy_d;
    logic [15:0]          drop_q, drop_d;

    logic                 hit_s, ins_s, upd_en_s, clr_s;
    logic [SLOT_W-1:0]    hit_idx_s, end_s;
    logic [CNT_W-1:0]     n_s, j_s, n_next_s;

    // Table next state: locate match and insert point, then shift slots j..end down by one.
    always_comb begin
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        hit_s     = 1'b0;
        hit_idx_s = '0;
        j_s       = '0;
        ins_s     = 1'b0;
        end_s     = '0;
        n_s       = popcount(valid_q);

        // Sorted table: entries with cnt >= in_cnt form a prefix, so their count is the
        // insert point in every case (a raised entry's own slot never counts).
        for (int i = 0; i < K; i++) begin
            if (valid_q[i] && (addr_q[i] == tk_if.in_addr) && !hit_s) begin
                hit_s     = 1'b1;
                hit_idx_s = SLOT_W'(i);
            end else begin
                hit_s     = hit_s;
            end
            if (valid_q[i] && (cnt_q[i] >= tk_if.in_cnt)) begin
                j_s = j_s + CNT_W'(1);
            end else begin
                j_s = j_s;
            end
        end

        if (hit_s) begin
            ins_s = (tk_if.in_cnt > cnt_q[hit_idx_s]);
            end_s = hit_idx_s;
        end else if (!valid_q[K-1]) begin
            ins_s = 1'b1;
            end_s = SLOT_W'(n_s);
        end else begin
            ins_s = (tk_if.in_cnt > cnt_q[K-1]);
            end_s = SLOT_W'(K - 1);
        end

        upd_en_s = (state_q == ST_IDLE) && tk_if.in_valid && ins_s;
        clr_s    = CLEAR_ON_DRAIN && (state_q == ST_CLEAR);

        if (clr_s) begin
            for (int i = 0; i < K; i++) begin
                addr_d[i] = '0;
                cnt_d[i]  = '0;
            end
            valid_d = '0;
        end else if (upd_en_s) begin
            for (int i = 1; i < K; i++) begin
                if ((i > int'(j_s)) && (i <= int'(end_s))) begin
                    addr_d[i] = addr_q[i-1];
                    cnt_d[i]  = cnt_q[i-1];
                end else begin
                    addr_d[i] = addr_d[i];
                end
            end
            for (int i = 0; i < K; i++) begin
                if (i == int'(j_s)) begin
                    addr_d[i] = tk_if.in_addr;
                    cnt_d[i]  = tk_if.in_cnt;
                end else begin
                    cnt_d[i]  = cnt_d[i];
                end
                if (i <= int'(end_s)) begin
                    valid_d[i] = 1'b1;
                end else begin
                    valid_d[i] = valid_q[i];
                end
            end
        end else begin
            valid_d = valid_q;
        end

        n_next_s = popcount(valid_d);
    end

    // Drain FSM and registered output next state; the first beat snapshots the post-update table.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_cnt_d   = out_cnt_q;
        out_last_d  = out_last_q;
        beat_nxt_s  = beat_q + SLOT_W'(1);
        drop_d      = drop_q;

        case (state_q)
            ST_IDLE: begin
                if (tk_if.drain_start) begin
                    if (n_next_s == '0) begin
                        state_d = ST_CLEAR;
                    end else begin
                        state_d     = ST_DRAIN;
                        beat_d      = '0;
                        out_valid_d = 1'b1;
                        out_addr_d  = addr_d[0];
                        out_cnt_d   = cnt_d[0];
                        out_last_d  = (n_next_s == CNT_W'(1));
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && tk_if.out_ready) begin
                    if (out_last_q) begin
                        state_d     = CLEAR_ON_DRAIN ? ST_CLEAR : ST_IDLE;
                        out_valid_d = 1'b0;
                        out_addr_d  = '0;
                        out_cnt_d   = '0;
                        out_last_d  = 1'b0;
                    end else begin
                        beat_d      = beat_nxt_s;
                        out_addr_d  = addr_q[beat_nxt_s];
                        out_cnt_d   = cnt_q[beat_nxt_s];
                        out_last_d  = (int'(beat_nxt_s) == (int'(n_s) - 1));
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        if ((state_q != ST_IDLE) && tk_if.in_valid && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // State, table and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) begin
                addr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            valid_q     <= '0;
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_cnt_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 16'd0;
        end else begin
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            state_q     <= state_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_cnt_q   <= out_cnt_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    assign tk_if.out_valid = out_valid_q;
    assign tk_if.out_addr  = out_addr_q;
    assign tk_if.out_cnt   = out_cnt_q;
    assign tk_if.out_last  = out_last_q;
    assign tk_if.busy      = busy_q;
    assign tk_if.drop_cnt  = drop_q;

endmodule

// File: tb/tb_hot_page_topk.sv
// Directed bench for hot_page_topk: sorted insert/raise/tie cases, drains with
// backpressure, drop counting and asynchronous reset mid-drain.
module tb_hot_page_topk;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [21:0] ea [8];
    logic [31:0] ec [8];

    hot_page_topk_if #(.ADDR_SIZE(22), .CNT_SIZE(32)) tk_if ();

    hot_page_topk #(.K(8), .ADDR_SIZE(22), .CNT_SIZE(32), .CLEAR_ON_DRAIN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tk_if (tk_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [21:0] a, input logic [31:0] c);
        tk_if.in_valid = 1'b1;
        tk_if.in_addr  = a;
        tk_if.in_cnt   = c;
        @(posedge clk); #1;
        tk_if.in_valid = 1'b0;
    endtask

    task automatic set_exp(input int i, input logic [21:0] a, input logic [31:0] c);
        ea[i] = a;
        ec[i] = c;
    endtask

    // Drain n beats against ea/ec; optional ready toggling, drops during holds, co-issued input.
    task automatic drain_check(input string nm, input int n, input bit toggle, input bit inject,
                               input bit co_in, input logic [21:0] co_a, input logic [31:0] co_c);
        tk_if.drain_start = 1'b1;
        if (co_in) begin
            tk_if.in_valid = 1'b1;
            tk_if.in_addr  = co_a;
            tk_if.in_cnt   = co_c;
        end
        @(posedge clk); #1;
        tk_if.drain_start = 1'b0;
        tk_if.in_valid    = 1'b0;
        chk({nm, "_busy"}, tk_if.busy, 1);
        for (int b = 0; b < n; b++) begin
            chk($sformatf("%s_b%0d_valid", nm, b), tk_if.out_valid, 1);
            chk($sformatf("%s_b%0d_addr", nm, b), tk_if.out_addr, ea[b]);
            chk($sformatf("%s_b%0d_cnt", nm, b), tk_if.out_cnt, ec[b]);
            chk($sformatf("%s_b%0d_last", nm, b), tk_if.out_last, (b == n - 1));
            if (toggle) begin
                tk_if.out_ready = 1'b0;
                if (inject) begin
                    tk_if.in_valid = 1'b1;
                    tk_if.in_addr  = 22'h77;
                    tk_if.in_cnt   = 32'd500;
                end
                @(posedge clk); #1;
                tk_if.in_valid = 1'b0;
                chk($sformatf("%s_b%0d_hold_valid", nm, b), tk_if.out_valid, 1);
                chk($sformatf("%s_b%0d_hold_addr", nm, b), tk_if.out_addr, ea[b]);
                chk($sformatf("%s_b%0d_hold_cnt", nm, b), tk_if.out_cnt, ec[b]);
            end
            tk_if.out_ready = 1'b1;
            @(posedge clk); #1;
            tk_if.out_ready = 1'b0;
        end
        chk({nm, "_post_valid"}, tk_if.out_valid, 0);
        chk({nm, "_clear_busy"}, tk_if.busy, 1);
        @(posedge clk); #1;
        chk({nm, "_idle_busy"}, tk_if.busy, 0);
    endtask

    task automatic empty_drain(input string nm);
        tk_if.drain_start = 1'b1;
        @(posedge clk); #1;
        tk_if.drain_start = 1'b0;
        chk({nm, "_pulse_busy"}, tk_if.busy, 1);
        chk({nm, "_pulse_valid"}, tk_if.out_valid, 0);
        @(posedge clk); #1;
        chk({nm, "_after_busy"}, tk_if.busy, 0);
        chk({nm, "_after_valid"}, tk_if.out_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        checks            = 0;
        failures          = 0;
        rst_n             = 1'b0;
        tk_if.in_valid    = 1'b0;
        tk_if.in_addr     = 22'h0;
        tk_if.in_cnt      = 32'd0;
        tk_if.drain_start = 1'b0;
        tk_if.out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", tk_if.out_valid, 0);
        chk("rst_out_addr", tk_if.out_addr, 0);
        chk("rst_out_cnt", tk_if.out_cnt, 0);
        chk("rst_out_last", tk_if.out_last, 0);
        chk("rst_busy", tk_if.busy, 0);
        chk("rst_drop", tk_if.drop_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: three inserts into an empty table, then drain.
        send(22'h10, 32'd5);
        send(22'h20, 32'd9);
        send(22'h30, 32'd7);
        set_exp(0, 22'h20, 32'd9);
        set_exp(1, 22'h30, 32'd7);
        set_exp(2, 22'h10, 32'd5);
        drain_check("t1", 3, 1'b0, 1'b0, 1'b0, 22'h0, 32'd0);
        empty_drain("t1_empty");

        // Test 2: fill, reject a cold entry, evict the coldest.
        for (int i = 1; i <= 8; i++) send(22'(i), 32'(10 * i));
        send(22'h99, 32'd5);
        send(22'h99, 32'd15);
        for (int b = 0; b < 7; b++) set_exp(b, 22'(8 - b), 32'(10 * (8 - b)));
        set_exp(7, 22'h99, 32'd15);
        drain_check("t2", 8, 1'b0, 1'b0, 1'b0, 22'h0, 32'd0);

        // Test 3: raise an existing entry, then a lower re-report is ignored.
        send(22'hA, 32'd50);
        send(22'hB, 32'd40);
        send(22'hC, 32'd30);
        send(22'hC, 32'd45);
        send(22'hC, 32'd20);
        set_exp(0, 22'hA, 32'd50);
        set_exp(1, 22'hC, 32'd45);
        set_exp(2, 22'hB, 32'd40);
        drain_check("t3", 3, 1'b0, 1'b0, 1'b0, 22'h0, 32'd0);

        // Test 4: ties keep arrival order; third entry arrives with drain_start.
        send(22'hA, 32'd40);
        send(22'hB, 32'd40);
        set_exp(0, 22'hA, 32'd40);
        set_exp(1, 22'hB, 32'd40);
        set_exp(2, 22'hC, 32'd40);
        drain_check("t4", 3, 1'b0, 1'b0, 1'b1, 22'hC, 32'd40);
        chk("t4_drop", tk_if.drop_cnt, 0);

        // Test 5: backpressured drain with three dropped inputs.
        send(22'hA1, 32'd100);
        send(22'hB2, 32'd60);
        send(22'hC3, 32'd80);
        set_exp(0, 22'hA1, 32'd100);
        set_exp(1, 22'hC3, 32'd80);
        set_exp(2, 22'hB2, 32'd60);
        drain_check("t5", 3, 1'b1, 1'b1, 1'b0, 22'h0, 32'd0);
        chk("t5_drop", tk_if.drop_cnt, 3);
        empty_drain("t5_empty");

        // Test 6: async reset while beat 2 is presented.
        send(22'h1, 32'd3);
        send(22'h2, 32'd2);
        send(22'h3, 32'd1);
        tk_if.drain_start = 1'b1;
        @(posedge clk); #1;
        tk_if.drain_start = 1'b0;
        tk_if.out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tk_if.out_ready = 1'b0;
        chk("t6_beat2_addr", tk_if.out_addr, 22'h3);
        chk("t6_beat2_last", tk_if.out_last, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", tk_if.out_valid, 0);
        chk("t6_rst_addr", tk_if.out_addr, 0);
        chk("t6_rst_cnt", tk_if.out_cnt, 0);
        chk("t6_rst_last", tk_if.out_last, 0);
        chk("t6_rst_busy", tk_if.busy, 0);
        chk("t6_rst_drop", tk_if.drop_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_idle_busy", tk_if.busy, 0);
        empty_drain("t6_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
